mem_bus_arbiter: RTL

Arbitrates the CPU instruction bus (ibus) and data bus (dbus) onto a single shared memory port, so one RAM/flash controller serves both. It sits between `naive_mips` and the memory controller, drives `ibus_stall`/`dbus_stall` back to the core, and bounds every access with a watchdog so a dead device cannot hang the pipeline.

---
 rtl/mem_bus_arbiter_if.sv | 48 ++++
 rtl/mem_bus_arbiter.sv | 136 +++++++++++++
 2 files changed

// File: rtl/mem_bus_arbiter_if.sv
// Core-side and memory-side bus bundle for mem_bus_arbiter.
// slave = arbiter view, master = core/memory environment view.
interface mem_bus_arbiter_if;
    logic [31:0] ibus_address;
    logic [3:0]  ibus_byteenable;
    logic        ibus_read;
    logic [31:0] ibus_rddata;
    logic        ibus_stall;
    logic [31:0] dbus_address;
    logic [3:0]  dbus_byteenable;
    logic        dbus_read;
    logic        dbus_write;
    logic [31:0] dbus_wrdata;
    logic [31:0] dbus_rddata;
    logic        dbus_stall;
    logic [31:0] mem_address;
    logic [3:0]  mem_byteenable;
    logic        mem_read;
    logic        mem_write;
    logic [31:0] mem_wrdata;
    logic [31:0] mem_rddata;
    logic        mem_ready;
    logic        bus_err;

    modport slave (
        input  ibus_address, ibus_byteenable, ibus_read,
        output ibus_rddata, ibus_stall,
        input  dbus_address, dbus_byteenable, dbus_read,
        input  dbus_write, dbus_wrdata,
        output dbus_rddata, dbus_stall,
        output mem_address, mem_byteenable, mem_read,
        output mem_write, mem_wrdata,
        input  mem_rddata, mem_ready,
        output bus_err
    );

    modport master (
        output ibus_address, ibus_byteenable, ibus_read,
        input  ibus_rddata, ibus_stall,
        output dbus_address, dbus_byteenable, dbus_read,
        output dbus_write, dbus_wrdata,
        input  dbus_rddata, dbus_stall,
        input  mem_address, mem_byteenable, mem_read,
        input  mem_write, mem_wrdata,
        output mem_rddata, mem_ready,
        input  bus_err
    );
endinterface

// File: rtl/mem_bus_arbiter.sv
// Shares one memory port between ibus and dbus with a watchdog abort.
// Define ARB_ROUND_ROBIN_EN for round-robin; default is dbus priority.
module mem_bus_arbiter #(
    parameter int unsigned TIMEOUT  = 255,
    parameter logic [31:0] ERR_DATA = 32'hDEADBEEF
) (
    input logic              clk,
    input logic              rst,
    mem_bus_arbiter_if.slave bus
);
    localparam logic [1:0] IDLE    = 2'd0;
    localparam logic [1:0] GRANT_I = 2'd1;
    localparam logic [1:0] GRANT_D = 2'd2;

    localparam bit          WD_EN   = (TIMEOUT != 0);
    localparam logic [31:0] WD_LAST = 32'(TIMEOUT - 1);

    logic [1:0]  state_q, state_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] wdat_q, wdat_d;
    logic [3:0]  be_q, be_d;
    logic        rd_q, rd_d;
    logic        wr_q, wr_d;
    logic        last_d_q, last_d_d;
    logic [31:0] wdog_q, wdog_d;
    logic        err_q;

    logic req_i, req_d, pick_d;
    logic gnt_i, gnt_d, grant;
    logic expire, done;

    assign req_i = bus.ibus_read;
    assign req_d = bus.dbus_read | bus.dbus_write;

`ifdef ARB_ROUND_ROBIN_EN
    // On contention, favour whichever bus did not win last time.
    assign pick_d = req_d & (~req_i | ~last_d_q);
`else
    assign pick_d = req_d;
`endif

    assign gnt_i  = (state_q == GRANT_I);
    assign gnt_d  = (state_q == GRANT_D);
    assign grant  = gnt_i | gnt_d;
    assign expire = WD_EN & grant & ~bus.mem_ready & (wdog_q == WD_LAST);
    assign done   = grant & (bus.mem_ready | expire);

    always_comb begin
        state_d  = state_q;
        addr_d   = addr_q;
        wdat_d   = wdat_q;
        be_d     = be_q;
        rd_d     = rd_q;
        wr_d     = wr_q;
        last_d_d = last_d_q;
        wdog_d   = wdog_q;
        unique case (state_q)
            IDLE: begin
                if (req_i | req_d) begin
                    wdog_d   = '0;
                    last_d_d = pick_d;
                    if (pick_d) begin
                        state_d = GRANT_D;
                        addr_d  = bus.dbus_address;
                        be_d    = bus.dbus_byteenable;
                        wdat_d  = bus.dbus_wrdata;
                        wr_d    = bus.dbus_write;
                        rd_d    = bus.dbus_read & ~bus.dbus_write;
                    end else begin
                        state_d = GRANT_I;
                        addr_d  = bus.ibus_address;
                        be_d    = bus.ibus_byteenable;
                        wr_d    = 1'b0;
                        rd_d    = 1'b1;
                    end
                end
            end
            GRANT_I, GRANT_D: begin
                if (done) begin
                    state_d = IDLE;
                    rd_d    = 1'b0;
                    wr_d    = 1'b0;
                end else if (WD_EN) begin
                    wdog_d = wdog_q + 32'd1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            addr_q   <= '0;
            wdat_q   <= '0;
            be_q     <= '0;
            rd_q     <= 1'b0;
            wr_q     <= 1'b0;
            last_d_q <= 1'b0;
            wdog_q   <= '0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            addr_q   <= addr_d;
            wdat_q   <= wdat_d;
            be_q     <= be_d;
            rd_q     <= rd_d;
            wr_q     <= wr_d;
            last_d_q <= last_d_d;
            wdog_q   <= wdog_d;
            err_q    <= expire;
        end
    end

    always_comb begin
        bus.ibus_rddata = '0;
        bus.dbus_rddata = '0;
        unique case (1'b1)
            gnt_i & bus.mem_ready: bus.ibus_rddata = bus.mem_rddata;
            gnt_i & expire:        bus.ibus_rddata = ERR_DATA;
            gnt_d & bus.mem_ready: bus.dbus_rddata = bus.mem_rddata;
            gnt_d & expire:        bus.dbus_rddata = ERR_DATA;
            default: ;
        endcase
    end

    assign bus.ibus_stall = req_i & ~(gnt_i & (bus.mem_ready | expire));
    assign bus.dbus_stall = req_d & ~(gnt_d & (bus.mem_ready | expire));

    assign bus.mem_address    = addr_q;
    assign bus.mem_byteenable = be_q;
    assign bus.mem_read       = rd_q;
    assign bus.mem_write      = wr_q;
    assign bus.mem_wrdata     = wdat_q;
    assign bus.bus_err        = err_q;
endmodule
